// File: rtl/shift_pipe.sv
// Two-stage shifter/rotator with valid/ready handshake and sideband tag.
// Optional rotate support (ROL/ROR) is enabled by defining SHIFT_PIPE_ROTATE_EN.
module shift_pipe #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_data,
  input  logic [$clog2(XLEN)-1:0] in_shamt,
  input  logic [2:0]              in_op,
  input  logic                    in_word,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_illegal
);

  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [2:0] OpSll = 3'b000;
  localparam logic [2:0] OpSrl = 3'b001;
  localparam logic [2:0] OpSra = 3'b010;
`ifdef SHIFT_PIPE_ROTATE_EN
  localparam logic [2:0] OpRol = 3'b100;
  localparam logic [2:0] OpRor = 3'b101;
`endif

  // Shifts compose across stages, so both stages share one shifter description.
  function automatic logic [XLEN-1:0] do_shift(input logic [XLEN-1:0] v,
                                               input logic [SHW-1:0]  a,
                                               input logic [2:0]      op);
    logic [XLEN-1:0] r;
`ifdef SHIFT_PIPE_ROTATE_EN
    logic [SHW:0] ra;
    ra = (SHW + 1)'(XLEN) - {1'b0, a};
`endif
    case (op)
      OpSll:   r = v << a;
      OpSrl:   r = v >> a;
      OpSra:   r = $signed(v) >>> a;
`ifdef SHIFT_PIPE_ROTATE_EN
      OpRol:   r = (v << a) | (v >> ra);
      OpRor:   r = (v >> a) | (v << ra);
`endif
      default: r = v;
    endcase
    return r;
  endfunction

  logic                  s1_valid_q, s2_valid_q;
  logic [XLEN-1:0]       s1_data_q, s2_data_q;
  logic [1:0]            s1_fine_q;
  logic [2:0]            s1_op_q;
  logic                  s1_word_q, s1_ill_q, s2_ill_q;
  logic [TAG_W-1:0]      s1_tag_q, s2_tag_q;

  logic                  s1_adv, s2_adv;
  logic                  in_legal, in_word_eff;
  logic [XLEN-1:0]       in_prep;
  logic [SHW-1:0]        in_coarse;
  logic [XLEN-1:0]       s1_data_d, s2_data_d;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    in_legal = (in_op == OpSll) || (in_op == OpSrl) || (in_op == OpSra);
`ifdef SHIFT_PIPE_ROTATE_EN
    in_legal = in_legal || (in_op == OpRol) || (in_op == OpRor);
`endif
    in_word_eff = in_word && (XLEN == 64) && in_legal;
    in_prep     = in_data;
    in_coarse   = {in_shamt[SHW-1:2], 2'b00};
    if (in_word_eff) begin
      // A replicated word rotates like a 32-bit rotate in its low half.
      case (in_op)
        OpSra:   in_prep = XLEN'($signed(in_data[31:0]));
`ifdef SHIFT_PIPE_ROTATE_EN
        OpRol,
        OpRor:   in_prep = XLEN'({in_data[31:0], in_data[31:0]});
`endif
        default: in_prep = XLEN'(in_data[31:0]);
      endcase
      in_coarse[SHW-1] = 1'b0;
    end
    s1_data_d = in_legal ? do_shift(in_prep, in_coarse, in_op) : in_data;
  end

  always_comb begin
    s2_data_d = s1_ill_q ? s1_data_q : do_shift(s1_data_q, SHW'(s1_fine_q), s1_op_q);
    if (s1_word_q) begin
      s2_data_d = XLEN'($signed(s2_data_d[31:0]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_fine_q  <= '0;
      s1_op_q    <= '0;
      s1_word_q  <= 1'b0;
      s1_ill_q   <= 1'b0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_ill_q   <= 1'b0;
      s2_tag_q   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
      end
      if (s1_adv && in_valid) begin
        s1_data_q <= s1_data_d;
        s1_fine_q <= in_shamt[1:0];
        s1_op_q   <= in_op;
        s1_word_q <= in_word_eff;
        s1_ill_q  <= !in_legal;
        s1_tag_q  <= in_tag;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
      end
      if (s2_adv && s1_valid_q) begin
        s2_data_q <= s2_data_d;
        s2_ill_q  <= s1_ill_q;
        s2_tag_q  <= s1_tag_q;
      end
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_data    = s2_data_q;
  assign out_tag     = s2_tag_q;
  assign out_illegal = s2_ill_q;

endmodule
